// File: rtl/i2s_rx_deser.sv
// I2S microphone receiver: generates SCK/WS from HCLK and deserialises SD.
// Optional macro I2S_RX_MONO_EN keeps only left-slot samples.
module i2s_rx_deser #(
  parameter int CLK_DIV     = 4,
  parameter int SAMPLE_BITS = 24
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        en,
  input  logic        SD,
  output logic        SCK,
  output logic        WS,
  output logic [31:0] sample_data,
  output logic        sample_channel,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
  localparam logic [4:0] P_LAST  = 5'(SAMPLE_BITS);

  logic [7:0]             div;
  logic [5:0]             bitcnt;
  logic [SAMPLE_BITS-1:0] shreg;
  logic [SAMPLE_BITS-1:0] shnext;
  logic [31:0]            sext;
  logic [4:0]             p;
  logic                   tick;
  logic                   rise;
  logic                   fall;
  logic                   capture;
  logic                   last;
  logic                   done;
  logic                   ch_in;

  assign tick    = en && (div == DIV_MAX);
  assign rise    = tick && !SCK;
  assign fall    = tick && SCK;
  assign p       = bitcnt[4:0];
  assign capture = rise && (p != 5'd0) && (p <= P_LAST);
  assign last    = rise && (p == P_LAST);
  assign shnext  = {shreg[SAMPLE_BITS-2:0], SD};
  assign sext    = {{(32-SAMPLE_BITS){shnext[SAMPLE_BITS-1]}}, shnext};

  // WS follows the frame half; bitcnt only moves on fall events
  assign WS = bitcnt[5];

`ifdef I2S_RX_MONO_EN
  assign done  = last && !bitcnt[5];
  assign ch_in = 1'b0;
`else
  assign done  = last;
  assign ch_in = bitcnt[5];
`endif

  // Divider and bit clock; both idle low while disabled
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      div <= '0;
      SCK <= 1'b0;
    end else if (!en) begin
      div <= '0;
      SCK <= 1'b0;
    end else if (tick) begin
      div <= '0;
      SCK <= ~SCK;
    end else begin
      div <= div + 8'd1;
    end
  end

  // Bit position within the 64-period frame, advanced on SCK falls
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      bitcnt <= '0;
    end else if (!en) begin
      bitcnt <= '0;
    end else if (fall) begin
      bitcnt <= bitcnt + 6'd1;
    end
  end

  // Shift SD in MSB first on rising SCK inside the data window
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      shreg <= '0;
    end else if (!en) begin
      shreg <= '0;
    end else if (capture) begin
      shreg <= shnext;
    end
  end

  // Output holding register with valid/ready handshake and overrun
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sample_data    <= '0;
      sample_channel <= 1'b0;
      sample_valid   <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!sample_valid || sample_ready) begin
          sample_data    <= sext;
          sample_channel <= ch_in;
          sample_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Randomised and directed bench for i2s_rx_deser against a timing-level
// model that derives every event from the number of enabled HCLK edges.
module tb_i2s_rx_deser;

  localparam int K  = 4;
  localparam int SB = 24;
`ifdef I2S_RX_MONO_EN
  localparam bit MONO = 1'b1;
`else
  localparam bit MONO = 1'b0;
`endif
  localparam logic [31:0] MASK = (32'h1 << SB) - 32'h1;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        en = 1'b0;
  logic        SD = 1'b0;
  logic        SCK;
  logic        WS;
  logic [31:0] sample_data;
  logic        sample_channel;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        overrun;

  i2s_rx_deser #(.CLK_DIV(K), .SAMPLE_BITS(SB)) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .en(en),
    .SD(SD),
    .SCK(SCK),
    .WS(WS),
    .sample_data(sample_data),
    .sample_channel(sample_channel),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun(overrun)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit sd_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp,
               cyc_n);
    end
  endtask

  // Behavioural model state
  int          t = 0;
  int          tt, n, p, ch;
  logic [31:0] acc = '0;
  logic [31:0] newd;
  logic        newch;
  logic        comp;
  logic        m_valid = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_ch = 1'b0;
  logic        m_ovr = 1'b0;
  logic        e_sck = 1'b0;
  logic        e_ws = 1'b0;

  // Model update at each edge, then compare shortly after
  always begin
    @(posedge HCLK);
    cyc_n++;
    if (HRESET) begin
      t = 0; acc = '0; m_valid = 0; m_data = '0; m_ch = 0;
      m_ovr = 0; e_sck = 0; e_ws = 0;
    end else begin
      comp = 1'b0;
      m_ovr = 1'b0;
      newd = '0;
      newch = 1'b0;
      if (en) begin
        tt = t;
        t++;
        if (tt >= K - 1 && (tt - (K - 1)) % (2 * K) == 0) begin
          n  = (tt - (K - 1)) / (2 * K);
          p  = n % 32;
          ch = (n / 32) % 2;
          if (p >= 1 && p <= SB) acc = ((acc << 1) | 32'(SD)) & MASK;
          if (p == SB && (!MONO || ch == 0)) begin
            comp  = 1'b1;
            newd  = acc[SB-1] ? (acc | ~MASK) : acc;
            newch = MONO ? 1'b0 : 1'(ch);
          end
        end
        e_sck = 1'(((tt + 1) / K) % 2);
        e_ws  = 1'((((tt + 1) / (2 * K)) / 32) % 2);
      end else begin
        t = 0; acc = '0; e_sck = 0; e_ws = 0;
      end
      if (comp) begin
        if (!m_valid || sample_ready) begin
          m_valid = 1'b1; m_data = newd; m_ch = newch;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && sample_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("sck", 32'(SCK), 32'(e_sck));
    chk("ws", 32'(WS), 32'(e_ws));
    chk("valid", 32'(sample_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (m_valid || HRESET) begin
      chk("data", sample_data, m_data);
      chk("channel", 32'(sample_channel), 32'(m_ch));
    end
  end

  // SD source: a fixed left/right word pattern or random bits
  always @(negedge HCLK) begin
    int nn, pp, cc;
    logic [31:0] w;
    if (sd_mode) begin
      nn = (t + K) / (2 * K);
      pp = nn % 32;
      cc = (nn / 32) % 2;
      w  = cc ? 32'h123456 : 32'h800001;
      SD = (pp >= 1 && pp <= SB) ? w[SB-pp] : 1'b0;
    end else begin
      SD = 1'($urandom);
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge HCLK);
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    HRESET = 1'b1;
    en = 1'b0;
    cyc(3);
    HRESET = 1'b0;
    cyc(2);
  endtask

  task automatic wait_valid(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge HCLK);
      #2;
      if (sample_valid) begin
        at = cyc_n;
        break;
      end
    end
    if (at < 0) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic wait_t(input int target, input int bound);
    int i;
    for (i = 0; i < bound && t != target; i++) @(negedge HCLK);
    if (t != target) chk("wait_t_timeout", 32'(t), 32'(target));
  endtask

  initial begin
    int c1, c2, ovr_cnt;
    int rdy_pct;

    // Reset with en high: outputs held at zero, SCK static
    HRESET = 1'b1;
    en = 1'b1;
    cyc(20);
    chk("rst_sck", 32'(SCK), 0);
    chk("rst_data", sample_data, 0);
    @(negedge HCLK);
    en = 1'b0;
    HRESET = 1'b0;
    cyc(20);
    chk("idle_sck", 32'(SCK), 0);

    // Capture of known left/right words with ready high
    sd_mode = 1'b1;
    sample_ready = 1'b1;
    @(negedge HCLK);
    en = 1'b1;
    wait_valid(600, c1);
    chk("cap_left", sample_data, 32'hFF800001);
    chk("cap_left_ch", 32'(sample_channel), 0);
    @(negedge HCLK);
    wait_valid(700, c2);
    if (MONO) begin
      chk("cap2_data", sample_data, 32'hFF800001);
      chk("cap2_ch", 32'(sample_channel), 0);
      chk("cap2_gap", 32'(c2 - c1), 512);
    end else begin
      chk("cap_right", sample_data, 32'h00123456);
      chk("cap_right_ch", 32'(sample_channel), 1);
      chk("cap_gap", 32'(c2 - c1), 256);
    end

    // Backpressure across two completions
    do_reset();
    sample_ready = 1'b0;
    en = 1'b1;
    ovr_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge HCLK);
      #2;
      if (overrun) ovr_cnt++;
    end
    chk("bp_ovr_count", 32'(ovr_cnt), MONO ? 0 : 1);
    chk("bp_valid", 32'(sample_valid), 1);
    chk("bp_data", sample_data, 32'hFF800001);
    @(negedge HCLK);
    sample_ready = 1'b1;
    @(posedge HCLK);
    #2;
    chk("bp_drained", 32'(sample_valid), 0);

    // Ready rises in the exact right-slot completion cycle
    do_reset();
    sample_ready = 1'b0;
    en = 1'b1;
    wait_t(K - 1 + 2 * K * 56, 1000);
    sample_ready = 1'b1;
    @(posedge HCLK);
    #2;
    chk("sim_ovr", 32'(overrun), 0);
    if (MONO) begin
      chk("sim_valid", 32'(sample_valid), 0);
    end else begin
      chk("sim_valid", 32'(sample_valid), 1);
      chk("sim_data", sample_data, 32'h00123456);
    end

    // Abort mid-slot at p=10, then restart
    do_reset();
    sample_ready = 1'b1;
    en = 1'b1;
    wait_t(K - 1 + 2 * K * 10 - 2, 200);
    en = 1'b0;
    @(posedge HCLK);
    #2;
    chk("abort_sck", 32'(SCK), 0);
    chk("abort_ws", 32'(WS), 0);
    cyc(50);
    chk("abort_nosample", 32'(sample_valid), 0);
    en = 1'b1;
    wait_valid(600, c1);
    chk("restart_data", sample_data, 32'hFF800001);
    chk("restart_ch", 32'(sample_channel), 0);

    // Randomised traffic with toggling enable, ready and resets
    sd_mode = 1'b0;
    rdy_pct = 50;
    for (int i = 0; i < 24000; i++) begin
      @(negedge HCLK);
      if (i % 2000 == 0) rdy_pct = $urandom_range(0, 100);
      sample_ready = ($urandom_range(0, 99) < rdy_pct);
      if ($urandom_range(0, 1499) == 0) en = ~en;
      else if (!en && $urandom_range(0, 40) == 0) en = 1'b1;
      HRESET = ($urandom_range(0, 6999) == 0);
    end
    HRESET = 1'b0;
    cyc(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
